// File: rtl/data_bus_unit_pkg.sv
// Shared data-bus definitions: peripheral addresses, RAM window and address decode.
// Reused by the instruction side and test code, so keep it free of design state.
package data_bus_unit_pkg;

    localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
    localparam logic [31:0] ADDR_LEDR    = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_SW      = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_KEYEDGE = 32'hFFFF_0008;
    localparam logic [31:0] ADDR_CYCLE   = 32'hFFFF_000C;
    localparam logic [31:0] ADDR_RELOAD  = 32'hFFFF_0010;
    localparam logic [31:0] ADDR_TIMER   = 32'hFFFF_0014;
    localparam logic [31:0] ADDR_TSTAT   = 32'hFFFF_0018;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LEDR,
        SEL_SW,
        SEL_KEYEDGE,
        SEL_CYCLE,
        SEL_RELOAD,
        SEL_TIMER,
        SEL_TSTAT
    } bus_sel_e;

    function automatic logic [31:0] ram_limit(input int unsigned words);
        return RAM_BASE + words * 4 - 1;
    endfunction

    // Byte-lane bits are ignored; any address outside the map selects nothing.
    function automatic bus_sel_e decode_addr(input logic [31:0] addr, input int unsigned words);
        logic [31:0] word_addr;
        word_addr = {addr[31:2], 2'b00};
        if (word_addr <= ram_limit(words)) return SEL_RAM;
        case (word_addr)
            ADDR_LEDR:    return SEL_LEDR;
            ADDR_SW:      return SEL_SW;
            ADDR_KEYEDGE: return SEL_KEYEDGE;
            ADDR_CYCLE:   return SEL_CYCLE;
            ADDR_RELOAD:  return SEL_RELOAD;
            ADDR_TIMER:   return SEL_TIMER;
            ADDR_TSTAT:   return SEL_TSTAT;
            default:      return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/data_bus_unit_bit_synchronizer.sv
// Two-flop synchroniser for a bus of independent asynchronous bits.
module bit_synchronizer #(
    parameter int unsigned           WIDTH       = 1,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stage1_q <= RESET_VALUE;
            stage2_q <= RESET_VALUE;
        end else begin
            stage1_q <= data_i;
            stage2_q <= stage1_q;
        end
    end

    assign data_o = stage2_q;

endmodule

// File: rtl/data_bus_unit.sv
// Memory-stage data bus: routes loads/stores to data RAM or the board peripherals.
// Loads are combinational; stores commit on the next rising edge.
module data_bus_unit
    import data_bus_unit_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write_value,
    input  logic        memory_write_enable,
    output logic [31:0] memory_read_value,
    input  logic [17:0] SW,
    input  logic [3:0]  KEY,
    output logic [17:0] LEDR,
    output logic [8:0]  LEDG
);

    localparam int unsigned IDX_W = $clog2(RAM_WORDS);

    logic [31:0] ram_q [RAM_WORDS];

    logic [17:0] sw_sync;
    logic [3:0]  key_sync;
    logic [3:0]  key_prev_q;
    logic [17:0] ledr_q,    ledr_d;
    logic [3:0]  keyedge_q, keyedge_d;
    logic [31:0] cycle_q,   cycle_d;
    logic [31:0] reload_q,  reload_d;
    logic [31:0] timer_q,   timer_d;
    logic        expired_q, expired_d;

    bus_sel_e sel;
    logic     unused_addr_lsbs;

    assign sel              = decode_addr(memory_address, RAM_WORDS);
    assign unused_addr_lsbs = ^memory_address[1:0];

    bit_synchronizer #(.WIDTH(18), .RESET_VALUE(18'h0)) u_sw_sync (
        .clock  (clock),
        .reset  (reset),
        .data_i (SW),
        .data_o (sw_sync)
    );

    bit_synchronizer #(.WIDTH(4), .RESET_VALUE(4'hF)) u_key_sync (
        .clock  (clock),
        .reset  (reset),
        .data_i (KEY),
        .data_o (key_sync)
    );

    // RAM has no reset and still takes a store issued during reset.
    always_ff @(posedge clock) begin
        if (memory_write_enable && sel == SEL_RAM)
            ram_q[memory_address[IDX_W+1:2]] <= memory_write_value;
    end

    always_comb begin
        logic        timer_step;
        logic [3:0]  key_fall;
        logic [3:0]  key_clear;
        logic        tstat_clear;

        ledr_d    = ledr_q;
        cycle_d   = cycle_q + 32'd1;
        reload_d  = reload_q;
        timer_d   = timer_q;

        key_fall    = key_prev_q & ~key_sync;
        key_clear   = (memory_write_enable && sel == SEL_KEYEDGE) ? memory_write_value[3:0] : 4'h0;
        tstat_clear = memory_write_enable && sel == SEL_TSTAT && memory_write_value[0];
        timer_step  = (timer_q == 32'd1);

        if (timer_q != 32'd0)
            timer_d = timer_step ? reload_q : timer_q - 32'd1;

        if (memory_write_enable) begin
            case (sel)
                SEL_LEDR:   ledr_d = memory_write_value[17:0];
                SEL_CYCLE:  cycle_d = memory_write_value;
                SEL_RELOAD: begin
                    reload_d = memory_write_value;
                    timer_d  = memory_write_value;
                end
                default: ;
            endcase
        end

        // Set events take priority over write-1-to-clear.
        keyedge_d = key_fall | (keyedge_q & ~key_clear);
        expired_d = timer_step | (expired_q & ~tstat_clear);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_prev_q <= 4'hF;
            ledr_q     <= '0;
            keyedge_q  <= '0;
            cycle_q    <= '0;
            reload_q   <= '0;
            timer_q    <= '0;
            expired_q  <= 1'b0;
        end else begin
            key_prev_q <= key_sync;
            ledr_q     <= ledr_d;
            keyedge_q  <= keyedge_d;
            cycle_q    <= cycle_d;
            reload_q   <= reload_d;
            timer_q    <= timer_d;
            expired_q  <= expired_d;
        end
    end

    always_comb begin
        memory_read_value = 32'h0;
        case (sel)
            SEL_RAM:     memory_read_value = ram_q[memory_address[IDX_W+1:2]];
            SEL_LEDR:    memory_read_value = {14'h0, ledr_q};
            SEL_SW:      memory_read_value = {14'h0, sw_sync};
            SEL_KEYEDGE: memory_read_value = {28'h0, keyedge_q};
            SEL_CYCLE:   memory_read_value = cycle_q;
            SEL_RELOAD:  memory_read_value = reload_q;
            SEL_TIMER:   memory_read_value = timer_q;
            SEL_TSTAT:   memory_read_value = {31'h0, expired_q};
            default:     memory_read_value = 32'h0;
        endcase
    end

    assign LEDR = ledr_q;
    assign LEDG = {expired_q, 4'b0000, keyedge_q};

endmodule

// File: tb/tb_data_bus_unit.sv
// Directed test of data_bus_unit: RAM, LEDs, switch/key sync, cycle counter, timer, reset.
module tb_data_bus_unit;
    import data_bus_unit_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] memory_address;
    logic [31:0] memory_write_value;
    logic        memory_write_enable;
    logic [31:0] memory_read_value;
    logic [17:0] SW;
    logic [3:0]  KEY;
    logic [17:0] LEDR;
    logic [8:0]  LEDG;

    int checks = 0;
    int errors = 0;

    data_bus_unit #(.RAM_WORDS(1024)) dut (
        .clock               (clock),
        .reset               (reset),
        .memory_address      (memory_address),
        .memory_write_value  (memory_write_value),
        .memory_write_enable (memory_write_enable),
        .memory_read_value   (memory_read_value),
        .SW                  (SW),
        .KEY                 (KEY),
        .LEDR                (LEDR),
        .LEDG                (LEDG)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Store issued at a falling edge; returns at the next falling edge, after commit.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        memory_address      = addr;
        memory_write_value  = data;
        memory_write_enable = 1'b1;
        @(negedge clock);
        memory_write_enable = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        memory_address = addr;
        #1;
        check(tag, memory_read_value, exp);
    endtask

    initial begin
        reset               = 1'b1;
        memory_address      = '0;
        memory_write_value  = '0;
        memory_write_enable = 1'b0;
        SW                  = '0;
        KEY                 = 4'hF;
        step(2);

        // reset state
        check("rst_ledr", {14'h0, LEDR}, 32'h0);
        check("rst_ledg", {23'h0, LEDG}, 32'h0);
        rd("rst_cycle",   ADDR_CYCLE,   32'h0);
        rd("rst_timer",   ADDR_TIMER,   32'h0);
        rd("rst_keyedge", ADDR_KEYEDGE, 32'h0);
        rd("rst_sw",      ADDR_SW,      32'h0);
        reset = 1'b0;
        step(1);

        // RAM store / load
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_load",     32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_load_lsb", 32'h0000_0013, 32'hDEAD_BEEF);
        rd("ram_top_word_addr_aliases_none", 32'h0000_1000, 32'h0);

        // LEDR, unmapped
        wr(ADDR_LEDR, 32'hFFFF_FFFF);
        check("ledr_port", {14'h0, LEDR}, 32'h0003_FFFF);
        rd("ledr_read", ADDR_LEDR, 32'h0003_FFFF);
        rd("unmapped",  32'h1234_0000, 32'h0);
        wr(32'h1234_0000, 32'h5555_5555);
        rd("unmapped_wr", 32'h1234_0000, 32'h0);

        // SW through 2-flop sync
        SW = 18'h2A5A5;
        step(1);
        rd("sw_1cyc", ADDR_SW, 32'h0);
        step(1);
        rd("sw_2cyc", ADDR_SW, 32'h0002_A5A5);
        wr(ADDR_SW, 32'hFFFF_FFFF);
        rd("sw_ro", ADDR_SW, 32'h0002_A5A5);

        // KEY[2] press: visible in KEYEDGE on the 3rd edge
        KEY = 4'b1011;
        step(2);
        rd("key2_2cyc", ADDR_KEYEDGE, 32'h0);
        step(1);
        rd("key2_3cyc", ADDR_KEYEDGE, 32'h4);
        check("ledg_key2", {23'h0, LEDG}, 32'h004);

        // clear bit2 while KEY[0] latches
        KEY = 4'b1010;
        step(2);
        wr(ADDR_KEYEDGE, 32'h4);
        rd("key0_clr2", ADDR_KEYEDGE, 32'h1);

        // clear bit1 in the same cycle KEY[1] sets it: set wins
        KEY = 4'b1000;
        step(2);
        wr(ADDR_KEYEDGE, 32'h2);
        rd("key1_setwins", ADDR_KEYEDGE, 32'h3);
        wr(ADDR_KEYEDGE, 32'h3);
        rd("key_clr_all", ADDR_KEYEDGE, 32'h0);
        KEY = 4'hF;
        step(4);
        rd("key_release", ADDR_KEYEDGE, 32'h0);

        // periodic timer
        wr(ADDR_RELOAD, 32'd3);
        rd("tmr_3", ADDR_TIMER, 32'd3);
        rd("reload_rd", ADDR_RELOAD, 32'd3);
        step(1);
        rd("tmr_2", ADDR_TIMER, 32'd2);
        step(1);
        rd("tmr_1", ADDR_TIMER, 32'd1);
        rd("tstat_pre", ADDR_TSTAT, 32'h0);
        step(1);
        rd("tmr_reload", ADDR_TIMER, 32'd3);
        rd("tstat_set", ADDR_TSTAT, 32'h1);
        check("ledg_exp", {23'h0, LEDG}, 32'h100);
        wr(ADDR_TSTAT, 32'h1);
        rd("tstat_clr", ADDR_TSTAT, 32'h0);
        rd("tmr_2b", ADDR_TIMER, 32'd2);
        step(1);
        wr(ADDR_TSTAT, 32'h1);
        rd("tstat_setwins", ADDR_TSTAT, 32'h1);
        rd("tmr_3b", ADDR_TIMER, 32'd3);
        wr(ADDR_TSTAT, 32'h1);
        step(1);
        wr(ADDR_RELOAD, 32'd5);
        rd("tmr_rl_wr", ADDR_TIMER, 32'd5);
        rd("tstat_rl_wr", ADDR_TSTAT, 32'h1);
        wr(ADDR_TSTAT, 32'h1);
        wr(ADDR_RELOAD, 32'd0);
        step(3);
        rd("tmr_oneshot", ADDR_TIMER, 32'd0);
        rd("tstat_oneshot", ADDR_TSTAT, 32'h0);
        wr(ADDR_TIMER, 32'd7);
        rd("tmr_ro", ADDR_TIMER, 32'd0);

        // CYCLE wrap
        wr(ADDR_CYCLE, 32'hFFFF_FFFE);
        rd("cyc_fe", ADDR_CYCLE, 32'hFFFF_FFFE);
        step(1);
        rd("cyc_ff", ADDR_CYCLE, 32'hFFFF_FFFF);
        step(1);
        rd("cyc_wrap", ADDR_CYCLE, 32'h0);

        // reset mid-operation; RAM write during reset still lands
        wr(32'h0000_0020, 32'h1234_5678);
        wr(ADDR_LEDR, 32'h5);
        wr(ADDR_RELOAD, 32'd10);
        rd("pre_rst_timer", ADDR_TIMER, 32'd10);
        reset = 1'b1;
        wr(32'h0000_0024, 32'hCAFE_F00D);
        check("mrst_ledr", {14'h0, LEDR}, 32'h0);
        check("mrst_ledg", {23'h0, LEDG}, 32'h0);
        rd("mrst_cycle",  ADDR_CYCLE,  32'h0);
        rd("mrst_timer",  ADDR_TIMER,  32'h0);
        rd("mrst_reload", ADDR_RELOAD, 32'h0);
        rd("mrst_ram_kept", 32'h0000_0020, 32'h1234_5678);
        rd("mrst_ram_wr",   32'h0000_0024, 32'hCAFE_F00D);
        rd("mrst_ram_old",  32'h0000_0010, 32'hDEAD_BEEF);
        wr(ADDR_LEDR, 32'h7);
        check("mrst_ledr_drop", {14'h0, LEDR}, 32'h0);
        reset = 1'b0;
        step(1);
        rd("post_rst_cycle", ADDR_CYCLE, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
